mem_arbiter: RTL and testbench

//  Shares the single RAM port between instruction fetch (I) and data (D) requesters of the

---
 rtl/mem_arbiter_if.sv | 38 +++
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of the instruction-fetch, data and RAM-side signals around the
// memory arbiter. The arbiter takes the slave view; the CPU/RAM side (or a
// bench) takes the master view.
interface mem_arbiter_if;
    // instruction requester
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_done;
    logic [31:0] i_load;
    // data requester
    logic        d_ren;
    logic        d_wen;
    logic [31:0] d_addr;
    logic [31:0] d_store;
    logic        d_done;
    logic [31:0] d_load;
    // RAM port
    logic        ram_ren;
    logic        ram_wen;
    logic [31:0] ram_addr;
    logic [31:0] ram_store;
    logic [31:0] ram_load;
    logic        ram_rdy;
    // grant state visibility
    logic [1:0]  gnt_state;

    modport slave (
        input  i_req, i_addr, d_ren, d_wen, d_addr, d_store, ram_load, ram_rdy,
        output i_done, i_load, d_done, d_load,
               ram_ren, ram_wen, ram_addr, ram_store, gnt_state
    );

    modport master (
        output i_req, i_addr, d_ren, d_wen, d_addr, d_store, ram_load, ram_rdy,
        input  i_done, i_load, d_done, d_load,
               ram_ren, ram_wen, ram_addr, ram_store, gnt_state
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access.
// Data wins by default; after STARVE_LIMIT data grants taken while fetch was
// waiting, a pending fetch is forced through. One access in flight at a time,
// each held until the RAM reports ready, followed by at least one IDLE cycle.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4   // 1..15
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        IGNT = 2'b01,
        DGNT = 2'b10
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state_reg, state_next;
    logic [3:0]  starve_cnt_reg, starve_cnt_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] store_reg, store_next;
    logic        op_wr_reg, op_wr_next;
    logic        i_done_reg, i_done_next;
    logic        d_done_reg, d_done_next;
    logic [31:0] i_load_reg, i_load_next;
    logic [31:0] d_load_reg, d_load_next;
    logic        ram_ren_c, ram_wen_c;

    // Requests still flagged by a completion pulse this cycle are stale and ignored.
    logic dreq, ireq, starved;
    assign dreq    = (bus.d_ren | bus.d_wen) & ~d_done_reg;
    assign ireq    = bus.i_req & ~i_done_reg;
    assign starved = (starve_cnt_reg == LIMIT);

    // State and datapath registers; reset abandons any in-flight access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            starve_cnt_reg <= 4'd0;
            addr_reg       <= 32'd0;
            store_reg      <= 32'd0;
            op_wr_reg      <= 1'b0;
            i_done_reg     <= 1'b0;
            d_done_reg     <= 1'b0;
            i_load_reg     <= 32'd0;
            d_load_reg     <= 32'd0;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
            addr_reg       <= addr_next;
            store_reg      <= store_next;
            op_wr_reg      <= op_wr_next;
            i_done_reg     <= i_done_next;
            d_done_reg     <= d_done_next;
            i_load_reg     <= i_load_next;
            d_load_reg     <= d_load_next;
        end
    end

    // Grant decision, request latching and completion capture.
    always_comb begin
        state_next      = state_reg;
        starve_cnt_next = starve_cnt_reg;
        addr_next       = addr_reg;
        store_next      = store_reg;
        op_wr_next      = op_wr_reg;
        i_done_next     = 1'b0;
        d_done_next     = 1'b0;
        i_load_next     = i_load_reg;
        d_load_next     = d_load_reg;
        case (state_reg)
            IDLE: begin
                if (dreq && !(ireq && starved)) begin
                    state_next = DGNT;
                    addr_next  = bus.d_addr;
                    store_next = bus.d_store;
                    op_wr_next = bus.d_wen;        // write wins when both are set
                    if (bus.i_req)
                        starve_cnt_next = starved ? starve_cnt_reg : starve_cnt_reg + 4'd1;
                    else
                        starve_cnt_next = 4'd0;
                end else if (ireq) begin
                    state_next      = IGNT;
                    addr_next       = bus.i_addr;
                    starve_cnt_next = 4'd0;
                end
            end
            IGNT: begin
                if (bus.ram_rdy) begin
                    i_load_next = bus.ram_load;
                    i_done_next = 1'b1;
                    state_next  = IDLE;
                end
            end
            DGNT: begin
                if (bus.ram_rdy) begin
                    if (!op_wr_reg)
                        d_load_next = bus.ram_load;
                    d_done_next = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // RAM strobes follow the grant state; never both, none while idle.
    always_comb begin
        ram_ren_c = 1'b0;
        ram_wen_c = 1'b0;
        case (state_reg)
            IGNT:    ram_ren_c = 1'b1;
            DGNT: begin
                ram_ren_c = ~op_wr_reg;
                ram_wen_c = op_wr_reg;
            end
            default: ;
        endcase
    end

    assign bus.ram_ren   = ram_ren_c;
    assign bus.ram_wen   = ram_wen_c;
    assign bus.ram_addr  = addr_reg;
    assign bus.ram_store = store_reg;
    assign bus.i_done    = i_done_reg;
    assign bus.i_load    = i_load_reg;
    assign bus.d_done    = d_done_reg;
    assign bus.d_load    = d_load_reg;
    assign bus.gnt_state = state_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, simultaneous requests, RAM wait
// states, write priority, starvation release and asynchronous reset.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] i_q[$];     // expected fetched words
    logic [31:0] d_q[$];     // expected data-read words
    logic [1:0]  gnt_q[$];   // expected grant order

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pop the next expected grant and compare it with the current state.
    task automatic check_grant(input int idx);
        logic [1:0] e;
        if (gnt_q.size() == 0) begin
            e = 2'b11;
        end else begin
            e = gnt_q.pop_front();
        end
        check($sformatf("grant_order[%0d]", idx), {30'd0, bus.gnt_state}, {30'd0, e});
        $display("grant %0d: state=%b", idx, bus.gnt_state);
    endtask

    task automatic idle_inputs();
        bus.i_req   = 1'b0;
        bus.d_ren   = 1'b0;
        bus.d_wen   = 1'b0;
    endtask

    initial begin
        logic [31:0] e;
        bus.i_req    = 1'b0;
        bus.i_addr   = 32'd0;
        bus.d_ren    = 1'b0;
        bus.d_wen    = 1'b0;
        bus.d_addr   = 32'd0;
        bus.d_store  = 32'd0;
        bus.ram_load = 32'd0;
        bus.ram_rdy  = 1'b0;

        // ---- reset state
        step(); step();
        check("rst_state",   {30'd0, bus.gnt_state}, 32'd0);
        check("rst_ram_ren", {31'd0, bus.ram_ren}, 32'd0);
        check("rst_ram_addr", bus.ram_addr, 32'd0);
        rst = 1'b0;
        step();
        check("idle_state", {30'd0, bus.gnt_state}, 32'd0);

        // ---- lone fetch
        bus.i_req = 1'b1; bus.i_addr = 32'h40;
        bus.ram_rdy = 1'b1; bus.ram_load = 32'h8C220004;
        i_q.push_back(32'h8C220004);
        step();
        check("fetch_state",   {30'd0, bus.gnt_state}, 32'd1);
        check("fetch_ram_ren", {31'd0, bus.ram_ren}, 32'd1);
        check("fetch_ram_wen", {31'd0, bus.ram_wen}, 32'd0);
        check("fetch_addr",    bus.ram_addr, 32'h40);
        check("fetch_no_done", {31'd0, bus.i_done}, 32'd0);
        step();
        check("fetch_done",    {31'd0, bus.i_done}, 32'd1);
        check("fetch_idle",    {30'd0, bus.gnt_state}, 32'd0);
        e = i_q.pop_front();
        check("fetch_load",    bus.i_load, e);
        $display("fetch addr=40 load=%h", bus.i_load);
        bus.i_req = 1'b0;
        step();
        check("fetch_pulse_end", {31'd0, bus.i_done}, 32'd0);
        check("fetch_load_hold", bus.i_load, 32'h8C220004);

        // ---- simultaneous: data first, fetch after the done/idle cycle
        bus.i_req = 1'b1; bus.i_addr = 32'h80;
        bus.d_wen = 1'b1; bus.d_addr = 32'h100; bus.d_store = 32'hDEAD;
        bus.ram_load = 32'h12345678;
        i_q.push_back(32'h12345678);
        step();
        check("sim_dgnt",      {30'd0, bus.gnt_state}, 32'd2);
        check("sim_ram_wen",   {31'd0, bus.ram_wen}, 32'd1);
        check("sim_ram_ren",   {31'd0, bus.ram_ren}, 32'd0);
        check("sim_ram_store", bus.ram_store, 32'hDEAD);
        check("sim_ram_addr",  bus.ram_addr, 32'h100);
        step();
        check("sim_d_done",    {31'd0, bus.d_done}, 32'd1);
        check("sim_idle",      {30'd0, bus.gnt_state}, 32'd0);
        check("sim_no_dload",  bus.d_load, 32'd0);
        $display("write addr=100 data=dead");
        bus.d_wen = 1'b0;
        step();
        check("sim_ignt",      {30'd0, bus.gnt_state}, 32'd1);
        check("sim_i_addr",    bus.ram_addr, 32'h80);
        step();
        check("sim_i_done",    {31'd0, bus.i_done}, 32'd1);
        e = i_q.pop_front();
        check("sim_i_load",    bus.i_load, e);
        $display("fetch addr=80 load=%h", bus.i_load);
        bus.i_req = 1'b0;
        step();

        // ---- RAM wait states, address stable through d_addr changes
        bus.ram_rdy = 1'b0;
        bus.d_ren = 1'b1; bus.d_addr = 32'h200;
        d_q.push_back(32'hCAFEF00D);
        step();
        check("wait_dgnt", {30'd0, bus.gnt_state}, 32'd2);
        bus.d_addr = 32'h300;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("wait_ren[%0d]", k),  {31'd0, bus.ram_ren}, 32'd1);
            check($sformatf("wait_addr[%0d]", k), bus.ram_addr, 32'h200);
            check($sformatf("wait_nodone[%0d]", k), {31'd0, bus.d_done}, 32'd0);
            if (k < 4) step();
        end
        bus.ram_rdy = 1'b1; bus.ram_load = 32'hCAFEF00D;
        step();
        check("wait_done", {31'd0, bus.d_done}, 32'd1);
        e = d_q.pop_front();
        check("wait_load", bus.d_load, e);
        $display("read addr=200 load=%h", bus.d_load);
        bus.d_ren = 1'b0;
        // ram_rdy stays high while idle and must be ignored
        step();
        check("idle_rdy_state", {30'd0, bus.gnt_state}, 32'd0);
        check("idle_rdy_nodone", {31'd0, bus.d_done}, 32'd0);
        step();
        check("idle_rdy_state2", {30'd0, bus.gnt_state}, 32'd0);

        // ---- both strobes requested: write performed, no read strobe
        bus.ram_rdy = 1'b0;
        bus.d_ren = 1'b1; bus.d_wen = 1'b1;
        bus.d_addr = 32'h44; bus.d_store = 32'h55AA;
        step();
        check("both_wen", {31'd0, bus.ram_wen}, 32'd1);
        check("both_ren", {31'd0, bus.ram_ren}, 32'd0);
        step();
        check("both_ren_hold", {31'd0, bus.ram_ren}, 32'd0);
        check("both_store", bus.ram_store, 32'h55AA);
        bus.ram_rdy = 1'b1; bus.ram_load = 32'hBAD0BAD0;
        step();
        check("both_done", {31'd0, bus.d_done}, 32'd1);
        check("both_ren_done", {31'd0, bus.ram_ren}, 32'd0);
        check("both_dload_hold", bus.d_load, 32'hCAFEF00D);
        $display("write addr=44 data=55aa");
        idle_inputs();
        step();

        // ---- starvation: four data grants each taken while fetch waits,
        //      then the waiting fetch is forced through ahead of data.
        gnt_q = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
        bus.ram_load = 32'h0BADF00D;
        for (int n = 0; n < 4; n++) begin
            bus.i_req = 1'b1; bus.i_addr = 32'h400; bus.d_ren = 1'b1; bus.d_addr = 32'h500 + n;
            step();
            check_grant(n);
            // fetch withdraws for the done cycle so the next data grant is
            // again taken with fetch waiting
            bus.i_req = 1'b0;
            step();
            check($sformatf("starve_d_done[%0d]", n), {31'd0, bus.d_done}, 32'd1);
            step();
        end
        bus.i_req = 1'b1;
        step();
        check_grant(4);
        step();
        check("starve_i_done", {31'd0, bus.i_done}, 32'd1);
        bus.i_req = 1'b0;
        step();
        check_grant(5);
        step();
        check("starve_last_d_done", {31'd0, bus.d_done}, 32'd1);
        check("grant_q_empty", gnt_q.size(), 32'd0);
        idle_inputs();
        step();

        // ---- reset mid data access: abandoned, no done pulse
        bus.ram_rdy = 1'b0;
        bus.d_ren = 1'b1; bus.d_addr = 32'h600;
        step();
        check("rst_mid_dgnt", {30'd0, bus.gnt_state}, 32'd2);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_state",  {30'd0, bus.gnt_state}, 32'd0);
        check("rst_mid_ren",    {31'd0, bus.ram_ren}, 32'd0);
        check("rst_mid_addr",   bus.ram_addr, 32'd0);
        check("rst_mid_dload",  bus.d_load, 32'd0);
        check("rst_mid_iload",  bus.i_load, 32'd0);
        check("rst_mid_nodone", {31'd0, bus.d_done}, 32'd0);
        bus.ram_rdy = 1'b1;
        step();
        check("rst_hold_nodone", {31'd0, bus.d_done}, 32'd0);
        idle_inputs();
        rst = 1'b0;
        step();
        check("post_rst_nodone", {31'd0, bus.d_done}, 32'd0);
        check("post_rst_state",  {30'd0, bus.gnt_state}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
